// File: rtl/cv32e40p_ex_result_arbiter_if.sv
// Result-source and writeback bus for the EX result arbiter.
// slave  : arbiter side (takes source results, drives the WB head).
// master : environment side (EX units plus the WB stage).
// src_*  : per-source valid/ready handshake with packed waddr/wdata/err.
// wb_*   : FIFO head toward the register-file write port.
interface cv32e40p_ex_result_arbiter_if #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 6
);
  logic [NUM_SRC-1:0]        src_valid_i;
  logic [NUM_SRC-1:0]        src_ready_o;
  logic [NUM_SRC*ADDR_W-1:0] src_waddr_i;
  logic [NUM_SRC*DATA_W-1:0] src_wdata_i;
  logic [NUM_SRC-1:0]        src_err_i;
  logic                      wb_valid_o;
  logic                      wb_ready_i;
  logic [ADDR_W-1:0]         wb_waddr_o;
  logic [DATA_W-1:0]         wb_wdata_o;

  modport slave (
    input  src_valid_i, src_waddr_i, src_wdata_i, src_err_i, wb_ready_i,
    output src_ready_o, wb_valid_o, wb_waddr_o, wb_wdata_o
  );

  modport master (
    output src_valid_i, src_waddr_i, src_wdata_i, src_err_i, wb_ready_i,
    input  src_ready_o, wb_valid_o, wb_waddr_o, wb_wdata_o
  );
endinterface

// File: rtl/cv32e40p_ex_result_arbiter.sv
// EX-stage result arbiter: grants one of NUM_SRC result sources per cycle
// (fixed priority or round-robin) into a DEPTH-entry FIFO that feeds the
// register-file write port.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush_i           drop all queued results, no grant this cycle
//   bus (slave)       source handshakes in, WB head out
//   fifo_level_o      occupied FIFO entries
//   contention_o      two or more sources valid this cycle (combinational)
//   contention_cnt_o  saturating count of contention cycles
module cv32e40p_ex_result_arbiter #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned ARB_RR  = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  cv32e40p_ex_result_arbiter_if.slave bus,
  output logic [$clog2(DEPTH):0]     fifo_level_o,
  output logic                       contention_o,
  output logic [CNT_W-1:0]           contention_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned IDX_W = $clog2(NUM_SRC);

  logic [ADDR_W-1:0] mem_addr_q [DEPTH];
  logic [ADDR_W-1:0] mem_addr_d [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [DATA_W-1:0] mem_data_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W-1:0] src_addr_a [NUM_SRC];
  logic [DATA_W-1:0] src_data_a [NUM_SRC];

  logic              wb_valid;
  logic              pop;
  logic              can_accept;
  logic              found;
  logic [IDX_W-1:0]  sel;
  int unsigned       idx;
  logic              gnt;
  logic              push;

  // Unpack the flat source buses into per-source arrays.
  for (genvar i = 0; i < int'(NUM_SRC); i++) begin : g_unpack
    assign src_addr_a[i] = bus.src_waddr_i[i*ADDR_W +: ADDR_W];
    assign src_data_a[i] = bus.src_wdata_i[i*DATA_W +: DATA_W];
  end

  assign wb_valid   = (level_q != '0);
  assign pop        = wb_valid & bus.wb_ready_i;
  // A full FIFO still accepts when its head leaves in the same cycle.
  assign can_accept = ~rst & ~flush_i & ((level_q < LVL_W'(DEPTH)) | pop);

  // Winner search: scan from index 0 (fixed) or from the RR pointer.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = (ARB_RR != 0) ? ((32'(rr_ptr_q) + k) % NUM_SRC) : k;
      if (!found && bus.src_valid_i[IDX_W'(idx)]) begin
        found = 1'b1;
        sel   = IDX_W'(idx);
      end
    end
  end

  assign gnt  = can_accept & found;
  // Cancelled results and writes to x0 complete the handshake but are not queued.
  assign push = gnt & ~bus.src_err_i[sel] & (src_addr_a[sel] != '0);

  assign bus.src_ready_o = gnt ? (NUM_SRC'(1) << sel) : '0;
  assign contention_o    = ($countones(bus.src_valid_i) >= 2);

  // Next-state for FIFO, RR pointer and contention counter.
  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        mem_addr_d[wr_ptr_q] = src_addr_a[sel];
        mem_data_d[wr_ptr_q] = src_data_a[sel];
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    end

    if (gnt) begin
      rr_ptr_d = (32'(sel) == NUM_SRC - 1) ? '0 : sel + IDX_W'(1);
    end

    if (contention_o && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_addr_q[i] <= '0;
        mem_data_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.wb_valid_o = wb_valid;
  assign bus.wb_waddr_o = mem_addr_q[rd_ptr_q];
  assign bus.wb_wdata_o = mem_data_q[rd_ptr_q];
  assign fifo_level_o   = level_q;
  assign contention_cnt_o = cnt_q;

endmodule

// File: tb/tb_cv32e40p_ex_result_arbiter.sv
// Directed bench: fixed-priority, round-robin and narrow-counter instances.
module tb_cv32e40p_ex_result_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Fixed priority instance
  logic        flush_fp;
  logic [1:0]  level_fp;
  logic        cont_fp;
  logic [15:0] cnt_fp;
  cv32e40p_ex_result_arbiter_if #(.NUM_SRC(4), .DATA_W(32), .ADDR_W(6)) if_fp ();
  cv32e40p_ex_result_arbiter #(.NUM_SRC(4), .DATA_W(32), .ADDR_W(6), .DEPTH(2),
                               .ARB_RR(0), .CNT_W(16)) u_fp (
    .clk(clk), .rst(rst), .flush_i(flush_fp), .bus(if_fp.slave),
    .fifo_level_o(level_fp), .contention_o(cont_fp), .contention_cnt_o(cnt_fp));

  // Round-robin instance
  logic        flush_rr;
  logic [1:0]  level_rr;
  logic        cont_rr;
  logic [15:0] cnt_rr;
  cv32e40p_ex_result_arbiter_if #(.NUM_SRC(4), .DATA_W(32), .ADDR_W(6)) if_rr ();
  cv32e40p_ex_result_arbiter #(.NUM_SRC(4), .DATA_W(32), .ADDR_W(6), .DEPTH(2),
                               .ARB_RR(1), .CNT_W(16)) u_rr (
    .clk(clk), .rst(rst), .flush_i(flush_rr), .bus(if_rr.slave),
    .fifo_level_o(level_rr), .contention_o(cont_rr), .contention_cnt_o(cnt_rr));

  // 2-bit contention counter instance
  logic        flush_sat;
  logic [1:0]  level_sat;
  logic        cont_sat;
  logic [1:0]  cnt_sat;
  cv32e40p_ex_result_arbiter_if #(.NUM_SRC(4), .DATA_W(32), .ADDR_W(6)) if_sat ();
  cv32e40p_ex_result_arbiter #(.NUM_SRC(4), .DATA_W(32), .ADDR_W(6), .DEPTH(2),
                               .ARB_RR(0), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .flush_i(flush_sat), .bus(if_sat.slave),
    .fifo_level_o(level_sat), .contention_o(cont_sat), .contention_cnt_o(cnt_sat));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    flush_fp = 0; flush_rr = 0; flush_sat = 0;
    if_fp.src_valid_i  = '0; if_fp.src_waddr_i  = '0; if_fp.src_wdata_i  = '0;
    if_fp.src_err_i    = '0; if_fp.wb_ready_i   = 1'b0;
    if_rr.src_valid_i  = '0; if_rr.src_waddr_i  = '0; if_rr.src_wdata_i  = '0;
    if_rr.src_err_i    = '0; if_rr.wb_ready_i   = 1'b0;
    if_sat.src_valid_i = '0; if_sat.src_waddr_i = '0; if_sat.src_wdata_i = '0;
    if_sat.src_err_i   = '0; if_sat.wb_ready_i  = 1'b0;
  endtask

  task automatic set_fp(input int i, input logic [5:0] a, input logic [31:0] d, input logic e);
    if_fp.src_waddr_i[i*6 +: 6]  = a;
    if_fp.src_wdata_i[i*32 +: 32] = d;
    if_fp.src_err_i[i]           = e;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    tick(); tick();
    rst = 1'b0;
    n_cmp++; if (if_fp.wb_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_wb_valid got=%b exp=0", if_fp.wb_valid_o); end
    n_cmp++; if (if_fp.wb_waddr_o !== 6'd0) begin n_bad++; $display("FAIL rst_wb_waddr got=%h exp=0", if_fp.wb_waddr_o); end
    n_cmp++; if (if_fp.wb_wdata_o !== 32'd0) begin n_bad++; $display("FAIL rst_wb_wdata got=%h exp=0", if_fp.wb_wdata_o); end
    n_cmp++; if (level_fp !== 2'd0) begin n_bad++; $display("FAIL rst_level got=%0d exp=0", level_fp); end
    n_cmp++; if (cnt_fp !== 16'd0) begin n_bad++; $display("FAIL rst_cnt got=%0d exp=0", cnt_fp); end
    // Queue two entries with one contention cycle, then reset mid-operation.
    set_fp(0, 6'd1, 32'h100, 1'b0);
    set_fp(1, 6'd2, 32'h200, 1'b0);
    if_fp.src_valid_i = 4'b0011;
    #1;
    n_cmp++; if (if_fp.src_ready_o !== 4'b0001) begin n_bad++; $display("FAIL rst_pre_ready got=%b exp=0001", if_fp.src_ready_o); end
    tick();
    if_fp.src_valid_i = 4'b0010;
    tick();
    if_fp.src_valid_i = 4'b0000;
    n_cmp++; if (level_fp !== 2'd2) begin n_bad++; $display("FAIL rst_pre_level got=%0d exp=2", level_fp); end
    n_cmp++; if (cnt_fp !== 16'd1) begin n_bad++; $display("FAIL rst_pre_cnt got=%0d exp=1", cnt_fp); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (if_fp.wb_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_mid_wb_valid got=%b exp=0", if_fp.wb_valid_o); end
    n_cmp++; if (level_fp !== 2'd0) begin n_bad++; $display("FAIL rst_mid_level got=%0d exp=0", level_fp); end
    n_cmp++; if (cnt_fp !== 16'd0) begin n_bad++; $display("FAIL rst_mid_cnt got=%0d exp=0", cnt_fp); end
  endtask

  task automatic test_fixed_priority();
    if_fp.wb_ready_i = 1'b1;
    set_fp(1, 6'd5, 32'h11, 1'b0);
    set_fp(3, 6'd7, 32'h33, 1'b0);
    if_fp.src_valid_i = 4'b1010;
    #1;
    n_cmp++; if (if_fp.src_ready_o !== 4'b0010) begin n_bad++; $display("FAIL fp_ready1 got=%b exp=0010", if_fp.src_ready_o); end
    n_cmp++; if (cont_fp !== 1'b1) begin n_bad++; $display("FAIL fp_contention got=%b exp=1", cont_fp); end
    n_cmp++; if (if_fp.wb_valid_o !== 1'b0) begin n_bad++; $display("FAIL fp_no_early_wb got=%b exp=0", if_fp.wb_valid_o); end
    tick();
    n_cmp++; if (if_fp.wb_valid_o !== 1'b1 || if_fp.wb_waddr_o !== 6'd5 || if_fp.wb_wdata_o !== 32'h11) begin
      n_bad++; $display("FAIL fp_wb1 got=%b/%h/%h exp=1/05/00000011", if_fp.wb_valid_o, if_fp.wb_waddr_o, if_fp.wb_wdata_o); end
    if_fp.src_valid_i = 4'b1000;
    #1;
    n_cmp++; if (if_fp.src_ready_o !== 4'b1000) begin n_bad++; $display("FAIL fp_ready2 got=%b exp=1000", if_fp.src_ready_o); end
    tick();
    if_fp.src_valid_i = 4'b0000;
    n_cmp++; if (if_fp.wb_valid_o !== 1'b1 || if_fp.wb_waddr_o !== 6'd7 || if_fp.wb_wdata_o !== 32'h33) begin
      n_bad++; $display("FAIL fp_wb2 got=%b/%h/%h exp=1/07/00000033", if_fp.wb_valid_o, if_fp.wb_waddr_o, if_fp.wb_wdata_o); end
    n_cmp++; if (level_fp !== 2'd1) begin n_bad++; $display("FAIL fp_level got=%0d exp=1", level_fp); end
    n_cmp++; if (cnt_fp !== 16'd1) begin n_bad++; $display("FAIL fp_cnt got=%0d exp=1", cnt_fp); end
    tick();
    n_cmp++; if (if_fp.wb_valid_o !== 1'b0) begin n_bad++; $display("FAIL fp_drain got=%b exp=0", if_fp.wb_valid_o); end
  endtask

  task automatic test_round_robin();
    int pulses [4];
    for (int i = 0; i < 4; i++) begin
      pulses[i] = 0;
      if_rr.src_waddr_i[i*6 +: 6]   = 6'(i + 1);
      if_rr.src_wdata_i[i*32 +: 32] = 32'(16'hA0 + i);
    end
    if_rr.wb_ready_i  = 1'b1;
    if_rr.src_valid_i = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      #1;
      for (int i = 0; i < 4; i++) if (if_rr.src_ready_o[i]) pulses[i]++;
      n_cmp++; if (if_rr.src_ready_o !== 4'(1 << k)) begin n_bad++; $display("FAIL rr_grant%0d got=%b exp=%b", k, if_rr.src_ready_o, 4'(1 << k)); end
      tick();
      n_cmp++; if (if_rr.wb_waddr_o !== 6'(k + 1) || if_rr.wb_wdata_o !== 32'(16'hA0 + k)) begin
        n_bad++; $display("FAIL rr_wb%0d got=%h/%h exp=%h/%h", k, if_rr.wb_waddr_o, if_rr.wb_wdata_o, 6'(k + 1), 32'(16'hA0 + k)); end
    end
    if_rr.src_valid_i = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (pulses[i] != 1) begin n_bad++; $display("FAIL rr_pulses%0d got=%0d exp=1", i, pulses[i]); end
    end
    tick(); tick();
  endtask

  task automatic test_backpressure();
    if_fp.wb_ready_i = 1'b0;
    if_fp.src_valid_i = 4'b0001;
    set_fp(0, 6'd2, 32'hA, 1'b0);
    tick();
    set_fp(0, 6'd2, 32'hB, 1'b0);
    tick();
    set_fp(0, 6'd2, 32'hC, 1'b0);
    #1;
    n_cmp++; if (level_fp !== 2'd2) begin n_bad++; $display("FAIL bp_level_full got=%0d exp=2", level_fp); end
    n_cmp++; if (if_fp.src_ready_o !== 4'b0000) begin n_bad++; $display("FAIL bp_ready_full got=%b exp=0000", if_fp.src_ready_o); end
    n_cmp++; if (if_fp.wb_wdata_o !== 32'hA) begin n_bad++; $display("FAIL bp_head_stable got=%h exp=a", if_fp.wb_wdata_o); end
    tick();
    n_cmp++; if (if_fp.wb_wdata_o !== 32'hA || level_fp !== 2'd2) begin n_bad++; $display("FAIL bp_hold got=%h/%0d exp=a/2", if_fp.wb_wdata_o, level_fp); end
    if_fp.wb_ready_i = 1'b1;
    #1;
    n_cmp++; if (if_fp.src_ready_o !== 4'b0001) begin n_bad++; $display("FAIL bp_ready_pop got=%b exp=0001", if_fp.src_ready_o); end
    tick();
    if_fp.src_valid_i = 4'b0000;
    n_cmp++; if (level_fp !== 2'd2 || if_fp.wb_wdata_o !== 32'hB) begin n_bad++; $display("FAIL bp_pushpop got=%0d/%h exp=2/b", level_fp, if_fp.wb_wdata_o); end
    tick();
    n_cmp++; if (level_fp !== 2'd1 || if_fp.wb_wdata_o !== 32'hC) begin n_bad++; $display("FAIL bp_order got=%0d/%h exp=1/c", level_fp, if_fp.wb_wdata_o); end
    tick();
    n_cmp++; if (level_fp !== 2'd0 || if_fp.wb_valid_o !== 1'b0) begin n_bad++; $display("FAIL bp_empty got=%0d/%b exp=0/0", level_fp, if_fp.wb_valid_o); end
  endtask

  task automatic test_drops();
    if_fp.wb_ready_i = 1'b0;
    set_fp(2, 6'd9, 32'hDEAD, 1'b1);
    if_fp.src_valid_i = 4'b0100;
    #1;
    n_cmp++; if (if_fp.src_ready_o !== 4'b0100) begin n_bad++; $display("FAIL drop_err_ready got=%b exp=0100", if_fp.src_ready_o); end
    tick();
    n_cmp++; if (level_fp !== 2'd0 || if_fp.wb_valid_o !== 1'b0) begin n_bad++; $display("FAIL drop_err_push got=%0d/%b exp=0/0", level_fp, if_fp.wb_valid_o); end
    set_fp(2, 6'd0, 32'h0, 1'b0);
    set_fp(0, 6'd0, 32'hBEEF, 1'b0);
    if_fp.src_valid_i = 4'b0001;
    #1;
    n_cmp++; if (if_fp.src_ready_o !== 4'b0001) begin n_bad++; $display("FAIL drop_x0_ready got=%b exp=0001", if_fp.src_ready_o); end
    tick();
    if_fp.src_valid_i = 4'b0000;
    n_cmp++; if (level_fp !== 2'd0 || if_fp.wb_valid_o !== 1'b0) begin n_bad++; $display("FAIL drop_x0_push got=%0d/%b exp=0/0", level_fp, if_fp.wb_valid_o); end
  endtask

  task automatic test_flush();
    if_fp.wb_ready_i = 1'b0;
    if_fp.src_valid_i = 4'b0001;
    set_fp(0, 6'd3, 32'h1, 1'b0);
    tick();
    set_fp(0, 6'd3, 32'h2, 1'b0);
    tick();
    n_cmp++; if (level_fp !== 2'd2) begin n_bad++; $display("FAIL fl_pre_level got=%0d exp=2", level_fp); end
    set_fp(0, 6'd3, 32'h3, 1'b0);
    if_fp.wb_ready_i = 1'b1;
    flush_fp = 1'b1;
    #1;
    n_cmp++; if (if_fp.src_ready_o !== 4'b0000) begin n_bad++; $display("FAIL fl_ready got=%b exp=0000", if_fp.src_ready_o); end
    tick();
    flush_fp = 1'b0;
    if_fp.src_valid_i = 4'b0000;
    n_cmp++; if (level_fp !== 2'd0 || if_fp.wb_valid_o !== 1'b0) begin n_bad++; $display("FAIL fl_empty got=%0d/%b exp=0/0", level_fp, if_fp.wb_valid_o); end
    n_cmp++; if (cnt_fp !== 16'd1) begin n_bad++; $display("FAIL fl_cnt_kept got=%0d exp=1", cnt_fp); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    if_sat.src_waddr_i = {6'd4, 6'd3, 6'd2, 6'd1};
    if_sat.src_wdata_i = {32'h4, 32'h3, 32'h2, 32'h1};
    if_sat.wb_ready_i  = 1'b1;
    if_sat.src_valid_i = 4'b0011;
    #1;
    n_cmp++; if (cont_sat !== 1'b1) begin n_bad++; $display("FAIL sat_contention got=%b exp=1", cont_sat); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_cnt = (k < 3) ? 2'(k) : 2'd3;
      n_cmp++; if (cnt_sat !== exp_cnt) begin n_bad++; $display("FAIL sat_cnt%0d got=%0d exp=%0d", k, cnt_sat, exp_cnt); end
    end
    if_sat.src_valid_i = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_backpressure();
    test_drops();
    test_flush();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
